// File: rtl/bi_mem_tp_fifo_ctrl.sv
// bi_mem_tp_fifo_ctrl: valid/ready FIFO controller around an external two-port
// memory with registered read (1-cycle latency). The controller keeps a 2-entry
// output buffer that is fed by prefetch reads, so the stream runs at full rate.
// Optional build macro BI_MEM_TP_FIFO_CTRL_BYPASS_EN: when the memory and the
// read pipe are empty, a pushed word goes straight into the output buffer.
`timescale 1ns/1ps
module bi_mem_tp_fifo_ctrl #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  localparam int AW    = $clog2(HEIGHT),
  localparam int LW    = $clog2(HEIGHT+3)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inValid_i,
  output logic             inReady_o,
  input  logic [WIDTH-1:0] inData_i,
  output logic             outValid_o,
  input  logic             outReady_i,
  output logic [WIDTH-1:0] outData_o,
  output logic             memWriteEnable_o,
  output logic [AW-1:0]    memWriteAddr_o,
  output logic [WIDTH-1:0] memWriteData_o,
  output logic             memReadEnable_o,
  output logic [AW-1:0]    memReadAddr_o,
  input  logic [WIDTH-1:0] memReadData_i,
  output logic [LW-1:0]    level_o
);

  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            mem_count;
  logic                   pend;
  logic [1:0]             ob_count;
  logic [1:0][WIDTH-1:0]  ob_data;

  logic       push, pop, issue, bypass, mem_wr;
  logic [1:0] ob_left;
  logic [2:0] occ;

  // Strobes are gated by reset so nothing reaches the memory while held in
  // reset, even though inReady_o reads 1 there.
  assign inReady_o  = mem_count < (AW+1)'(HEIGHT);
  assign push       = rst_i && inValid_i && inReady_o;
  assign outValid_o = ob_count != 2'd0;
  assign pop        = outValid_o && outReady_i;
  assign outData_o  = ob_data[0];

  // Buffer entries left after this cycle's pop, and that plus the read in flight.
  assign ob_left = ob_count - {1'b0, pop};
  assign occ     = {1'b0, ob_count} + {2'b0, pend} - {2'b0, pop};

  // Issue only when the result is guaranteed a free slot when it lands.
  assign issue = rst_i && (mem_count != '0) && (occ <= 3'd1);

`ifdef BI_MEM_TP_FIFO_CTRL_BYPASS_EN
  // Nothing older is in memory or in flight, so skipping memory keeps order.
  assign bypass = push && (mem_count == '0) && !pend && (ob_left < 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign mem_wr           = push && !bypass;
  assign memWriteEnable_o = mem_wr;
  assign memWriteAddr_o   = wr_ptr;
  assign memWriteData_o   = inData_i;
  assign memReadEnable_o  = issue;
  assign memReadAddr_o    = rd_ptr;

  assign level_o = LW'(mem_count) + LW'(pend) + LW'(ob_count);

  // Memory-side bookkeeping: pointers, occupancy and the read-in-flight flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      pend      <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (issue)  rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + {{AW{1'b0}}, mem_wr} - {{AW{1'b0}}, issue};
      pend      <= issue;
    end
  end

  // Output buffer: shift on pop, then append the landing read (or bypassed
  // word) behind whatever remains; the later assignment wins on overlap.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ob_count <= 2'd0;
      ob_data  <= '0;
    end else begin
      ob_count <= ob_left + {1'b0, (pend || bypass)};
      if (pop) ob_data[0] <= ob_data[1];
      if (pend)        ob_data[ob_left[0]] <= memReadData_i;
      else if (bypass) ob_data[ob_left[0]] <= inData_i;
    end
  end

endmodule
